// File: rtl/bsg_manycore_pkg.sv
// Shared manycore wormhole definitions: header flit layout and DMA initiator state encodings.
package bsg_manycore_pkg;

  localparam int wh_flit_width_gp = 32;
  localparam int wh_cord_width_gp = 7;
  localparam int wh_len_width_gp  = 4;
  localparam int wh_cid_width_gp  = 1;
  localparam int wh_hdr_pad_width_gp = wh_flit_width_gp - 2*wh_cord_width_gp
                                       - wh_len_width_gp - 2*wh_cid_width_gp - 1;

  // Wormhole DMA header, declared MSB first so dest_cord lands in the LSBs.
  typedef struct packed {
    logic [wh_hdr_pad_width_gp-1:0] pad;
    logic [wh_cid_width_gp-1:0]     src_cid;
    logic [wh_cord_width_gp-1:0]    src_cord;
    logic                           write;
    logic [wh_cid_width_gp-1:0]     dest_cid;
    logic [wh_len_width_gp-1:0]     len;
    logic [wh_cord_width_gp-1:0]    dest_cord;
  } wh_dma_header_s;

  typedef enum logic [1:0] {
    e_tx_idle,
    e_tx_hdr,
    e_tx_addr,
    e_tx_data
  } tx_state_e;

  typedef enum logic {
    e_rx_hdr,
    e_rx_data
  } rx_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter; simultaneous up and down leave the count unchanged.
module bsg_counter_up_down #(
  parameter int max_val_p  = 4,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  localparam int ptr_width_lp  = $clog2(max_val_p + 1),
  localparam int step_width_lp = $clog2(max_step_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [step_width_lp-1:0] up_i,
  input  logic [step_width_lp-1:0] down_i,
  output logic [ptr_width_lp-1:0]  count_o
);

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= ptr_width_lp'(init_val_p);
    else
      count_o <= count_o - ptr_width_lp'(down_i) + ptr_width_lp'(up_i);
  end

endmodule

// File: rtl/bsg_manycore_wh_dma_initiator.sv
// Wormhole DMA initiator: turns block read/write requests into wormhole packets
// and streams read responses back, with a bounded number of outstanding reads.
module bsg_manycore_wh_dma_initiator
  import bsg_manycore_pkg::*;
#(
  parameter int wh_flit_width_p       = 32,
  parameter int wh_cord_width_p       = 7,
  parameter int wh_len_width_p        = 4,
  parameter int wh_cid_width_p        = 1,
  parameter int addr_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int max_outstanding_p     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [wh_cord_width_p-1:0] my_cord_i,
  input  logic [wh_cid_width_p-1:0]  my_cid_i,
  input  logic [wh_cord_width_p-1:0] dest_cord_i,
  input  logic                       dma_pkt_v_i,
  output logic                       dma_pkt_ready_and_o,
  input  logic                       dma_pkt_write_i,
  input  logic [addr_width_p-1:0]    dma_pkt_addr_i,
  input  logic [wh_flit_width_p-1:0] dma_data_i,
  input  logic                       dma_data_v_i,
  output logic                       dma_data_yumi_o,
  output logic [wh_flit_width_p-1:0] dma_data_o,
  output logic                       dma_data_v_o,
  input  logic                       dma_data_ready_and_i,
  output logic [wh_flit_width_p-1:0] wh_data_o,
  output logic                       wh_v_o,
  input  logic                       wh_ready_and_i,
  input  logic [wh_flit_width_p-1:0] wh_data_i,
  input  logic                       wh_v_i,
  output logic                       wh_ready_and_o
);

  localparam int word_cnt_width_lp = $clog2(block_size_in_words_p);
  localparam int out_cnt_width_lp  = $clog2(max_outstanding_p + 1);
  localparam logic [word_cnt_width_lp-1:0] last_word_lp = word_cnt_width_lp'(block_size_in_words_p - 1);
  localparam logic [out_cnt_width_lp-1:0]  max_out_lp   = out_cnt_width_lp'(max_outstanding_p);
  localparam logic [wh_len_width_p-1:0]    write_len_lp = wh_len_width_p'(block_size_in_words_p + 1);
  localparam logic [wh_len_width_p-1:0]    read_len_lp  = wh_len_width_p'(1);
  localparam logic [wh_len_width_p-1:0]    rsp_len_lp   = wh_len_width_p'(block_size_in_words_p);

  // ---------------------------------------------------------------- TX side
  tx_state_e tx_state_r, tx_state_n;
  logic                         write_r;
  logic [addr_width_p-1:0]      addr_r;
  logic [wh_cord_width_p-1:0]   dest_r;
  logic [word_cnt_width_lp-1:0] word_cnt_r;
  logic [out_cnt_width_lp-1:0]  out_cnt;
  wh_dma_header_s               tx_header;
  logic tx_v, tx_yumi, pkt_ready, pkt_hs, read_sent;

  // Header flit assembled from the latched request and this tile's identity.
  always_comb begin
    tx_header           = '0;
    tx_header.dest_cord = dest_r;
    tx_header.len       = write_r ? write_len_lp : read_len_lp;
    tx_header.dest_cid  = '0;
    tx_header.write     = write_r;
    tx_header.src_cord  = my_cord_i;
    tx_header.src_cid   = my_cid_i;
  end

  // TX next-state and flit mux.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a variable unassigned and no latch is inferred.
    tx_state_n = tx_state_r;
    tx_v       = 1'b0;
    tx_yumi    = 1'b0;
    pkt_ready  = 1'b0;
    wh_data_o  = '0;
    unique case (tx_state_r)
      e_tx_idle: begin
        pkt_ready = dma_pkt_write_i | (out_cnt != max_out_lp);
        if (dma_pkt_v_i && pkt_ready) tx_state_n = e_tx_hdr;
      end
      e_tx_hdr: begin
        tx_v      = 1'b1;
        wh_data_o = tx_header;
        if (wh_ready_and_i) tx_state_n = e_tx_addr;
      end
      e_tx_addr: begin
        tx_v      = 1'b1;
        wh_data_o = wh_flit_width_p'(addr_r);
        if (wh_ready_and_i) tx_state_n = write_r ? e_tx_data : e_tx_idle;
      end
      e_tx_data: begin
        tx_v      = dma_data_v_i;
        wh_data_o = dma_data_i;
        tx_yumi   = dma_data_v_i & wh_ready_and_i;
        if (tx_yumi && (word_cnt_r == last_word_lp)) tx_state_n = e_tx_idle;
      end
      default: tx_state_n = e_tx_idle;
    endcase
  end

  // Handshake outputs are forced low while reset is held.
  assign dma_pkt_ready_and_o = reset_n_i & pkt_ready;
  assign wh_v_o              = reset_n_i & tx_v;
  assign dma_data_yumi_o     = reset_n_i & tx_yumi;
  assign pkt_hs              = dma_pkt_v_i & dma_pkt_ready_and_o;
  assign read_sent           = reset_n_i & (tx_state_r == e_tx_addr) & wh_ready_and_i & ~write_r;

  // TX state register and data word counter.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_state_r <= e_tx_idle;
      word_cnt_r <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      tx_state_r <= tx_state_n;
      if (dma_data_yumi_o)
        word_cnt_r <= (word_cnt_r == last_word_lp) ? '0 : word_cnt_r + word_cnt_width_lp'(1);
    end
  end

  // Request capture on the IDLE handshake.
  always_ff @(posedge clk_i) begin
    // NOTE: these are pure datapath holding registers, only read after a handshake loads them, so they carry no reset.
    if (pkt_hs) begin
      write_r <= dma_pkt_write_i;
      addr_r  <= dma_pkt_addr_i;
      dest_r  <= dest_cord_i;
    end
  end

  // ---------------------------------------------------------------- RX side
  rx_state_e rx_state_r, rx_state_n;
  logic [wh_len_width_p-1:0] len_cnt_r;
  wh_dma_header_s            rx_header;
  logic rx_v, rx_last, unused_rx_hdr_bits;

  assign rx_header          = wh_dma_header_s'(wh_data_i);
  assign unused_rx_hdr_bits = ^{rx_header.pad, rx_header.src_cid, rx_header.src_cord,
                                rx_header.write, rx_header.dest_cid, rx_header.dest_cord};

  // RX next-state: header beat is swallowed, data beats pass straight through.
  always_comb begin
    rx_state_n     = rx_state_r;
    wh_ready_and_o = 1'b0;
    rx_v           = 1'b0;
    rx_last        = 1'b0;
    unique case (rx_state_r)
      e_rx_hdr: begin
        wh_ready_and_o = 1'b1;
        if (wh_v_i) rx_state_n = e_rx_data;
      end
      e_rx_data: begin
        rx_v           = wh_v_i;
        wh_ready_and_o = dma_data_ready_and_i;
        if (wh_v_i && dma_data_ready_and_i && (len_cnt_r == wh_len_width_p'(1))) begin
          rx_last    = 1'b1;
          rx_state_n = e_rx_hdr;
        end
      end
      default: rx_state_n = e_rx_hdr;
    endcase
  end

  assign dma_data_o   = wh_data_i;
  assign dma_data_v_o = reset_n_i & rx_v;

  // RX state register and remaining-length counter.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_state_r <= e_rx_hdr;
      len_cnt_r  <= '0;
    end else begin
      rx_state_r <= rx_state_n;
      if (rx_state_r == e_rx_hdr && wh_v_i)
        len_cnt_r <= rx_header.len;
      else if (rx_state_r == e_rx_data && wh_v_i && dma_data_ready_and_i)
        len_cnt_r <= len_cnt_r - wh_len_width_p'(1);
    end
  end

  // Outstanding reads: up when a read address flit leaves, down when its response ends.
  bsg_counter_up_down #(
    .max_val_p (max_outstanding_p),
    .init_val_p(0),
    .max_step_p(1)
  ) out_counter (
    .clk_i  (clk_i),
    .reset_i(~reset_n_i),
    .up_i   (read_sent),
    .down_i (rx_last),
    .count_o(out_cnt)
  );

`ifndef SYNTHESIS
  // Responses must be full blocks and must match an outstanding read.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && rx_state_r == e_rx_hdr && wh_v_i) begin
      assert (rx_header.len == rsp_len_lp)
        else $error("response header length %0d is not a full block", rx_header.len);
      assert (out_cnt != '0)
        else $error("response received with no outstanding read");
    end
  end
`endif

endmodule
